// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the 2-read/1-write register file.
package regfile_pkg;

   typedef enum logic {
      RF_IDLE,
      RF_CLEAR
   } rf_state_t;

   localparam int RF_DATA_W = 8;
   localparam int RF_DEPTH  = 4;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range check, optional write-through, data/valid regs.
// Write-through is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_adr,
   input  logic [DEPTH-1:0][DATA_W-1:0] mem,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_adr,
   input  logic [DATA_W-1:0]            wr_data,
   output logic [DATA_W-1:0]            r_data,
   output logic                         r_valid
);

   logic              rd_hit;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] r_data_d, r_data_q;
   logic              r_valid_d, r_valid_q;

   always_comb begin
      rd_hit  = 1'b0;
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_adr == ADDR_W'(i)) begin
            rd_hit  = 1'b1;
            rd_word = mem[i];
         end
      end
`ifdef REGFILE_WR_BYPASS_EN
      if (rd_hit && wr_en && (rd_adr == wr_adr)) begin
         rd_word = wr_data;
      end
`endif
      if (!rd_hit) begin
         rd_word = '0;
      end
   end

`ifndef REGFILE_WR_BYPASS_EN
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_adr, wr_data};
`endif

   always_comb begin
      r_valid_d = rd_en;
      r_data_d  = rd_en ? rd_word : r_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_data_q  <= r_data_d;
         r_valid_q <= r_valid_d;
      end
   end

   assign r_data  = r_data_q;
   assign r_valid = r_valid_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: one write port, two registered read ports, clear sweep.
// Optional write-through on reads: define REGFILE_WR_BYPASS_EN.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter  int DATA_W = RF_DATA_W,
   parameter  int DEPTH  = RF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_adr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_en0,
   input  logic [ADDR_W-1:0] r_adr0,
   output logic [DATA_W-1:0] r_data0,
   output logic              r_valid0,
   input  logic              r_en1,
   input  logic [ADDR_W-1:0] r_adr1,
   output logic [DATA_W-1:0] r_data1,
   output logic              r_valid1,
   input  logic              clr,
   output logic              busy,
   output logic              w_err
);

   rf_state_t                  state_d, state_q;
   logic [ADDR_W-1:0]          cnt_d, cnt_q;
   logic [DEPTH-1:0][DATA_W-1:0] mem_d, mem_q;
   logic                       w_err_d, w_err_q;
   logic                       idle;
   logic                       w_in;
   logic                       wr_act;

   assign idle = (state_q == RF_IDLE);

   always_comb begin
      w_in = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_adr == ADDR_W'(i)) begin
            w_in = 1'b1;
         end
      end
   end

   // clr in the same cycle drops the write
   assign wr_act = idle & w_en & ~clr & w_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RF_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RF_IDLE: begin
            if (clr) begin
               state_d = RF_CLEAR;
               cnt_d   = '0;
            end
         end
         RF_CLEAR: begin
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = RF_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      busy = (state_q == RF_CLEAR);
   end

   always_comb begin
      mem_d   = mem_q;
      w_err_d = idle & w_en & ~clr & ~w_in;
      if (!idle) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == ADDR_W'(i)) begin
               mem_d[i] = '0;
            end
         end
      end else if (wr_act) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_adr == ADDR_W'(i)) begin
               mem_d[i] = w_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         w_err_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         w_err_q <= w_err_d;
      end
   end

   assign w_err = w_err_q;

   regfile_read_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rp0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (r_en0 & idle),
      .rd_adr  (r_adr0),
      .mem     (mem_q),
      .wr_en   (wr_act),
      .wr_adr  (w_adr),
      .wr_data (w_data),
      .r_data  (r_data0),
      .r_valid (r_valid0)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rp1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (r_en1 & idle),
      .rd_adr  (r_adr1),
      .mem     (mem_q),
      .wr_en   (wr_act),
      .wr_adr  (w_adr),
      .wr_data (w_data),
      .r_data  (r_data1),
      .r_valid (r_valid1)
   );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: DEPTH=4 instance plus a DEPTH=6 instance.
module tb_regfile_2r1w;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   logic       a_w_en, a_r_en0, a_r_en1, a_clr;
   logic [1:0] a_w_adr, a_r_adr0, a_r_adr1;
   logic [7:0] a_w_data, a_r_data0, a_r_data1;
   logic       a_r_valid0, a_r_valid1, a_busy, a_w_err;

   logic       b_w_en, b_r_en0, b_r_en1, b_clr;
   logic [2:0] b_w_adr, b_r_adr0, b_r_adr1;
   logic [7:0] b_w_data, b_r_data0, b_r_data1;
   logic       b_r_valid0, b_r_valid1, b_busy, b_w_err;

   int n_vec = 0;
   int n_err = 0;
   int cyc;
   logic [7:0] exp_same;

   regfile_2r1w #(.DATA_W(8), .DEPTH(4)) u_a (
      .clk(clk), .rst_n(rst_n),
      .w_en(a_w_en), .w_adr(a_w_adr), .w_data(a_w_data),
      .r_en0(a_r_en0), .r_adr0(a_r_adr0),
      .r_data0(a_r_data0), .r_valid0(a_r_valid0),
      .r_en1(a_r_en1), .r_adr1(a_r_adr1),
      .r_data1(a_r_data1), .r_valid1(a_r_valid1),
      .clr(a_clr), .busy(a_busy), .w_err(a_w_err)
   );

   regfile_2r1w #(.DATA_W(8), .DEPTH(6)) u_b (
      .clk(clk), .rst_n(rst_n),
      .w_en(b_w_en), .w_adr(b_w_adr), .w_data(b_w_data),
      .r_en0(b_r_en0), .r_adr0(b_r_adr0),
      .r_data0(b_r_data0), .r_valid0(b_r_valid0),
      .r_en1(b_r_en1), .r_adr1(b_r_adr1),
      .r_data1(b_r_data1), .r_valid1(b_r_valid1),
      .clr(b_clr), .busy(b_busy), .w_err(b_w_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_w_en = 0; a_r_en0 = 0; a_r_en1 = 0; a_clr = 0;
   endtask

   initial begin
      a_idle();
      a_w_adr = 0; a_w_data = 0; a_r_adr0 = 0; a_r_adr1 = 0;
      b_w_en = 0; b_r_en0 = 0; b_r_en1 = 0; b_clr = 0;
      b_w_adr = 0; b_w_data = 0; b_r_adr0 = 0; b_r_adr1 = 0;

      // reset
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst_rdata0", a_r_data0, 8'h00);
      chk("rst_rvalid", {a_r_valid0, a_r_valid1}, 2'b00);
      chk("rst_busy_werr", {a_busy, a_w_err}, 2'b00);
      rst_n = 1'b1;
      tick();

      // fill
      a_w_en = 1;
      a_w_adr = 0; a_w_data = 8'h8E; tick();
      a_w_adr = 1; a_w_data = 8'h86; tick();
      a_w_adr = 2; a_w_data = 8'h8C; tick();
      a_w_adr = 3; a_w_data = 8'hBE; tick();
      a_idle();
      chk("fill_werr", a_w_err, 1'b0);
      chk("fill_rvalid", {a_r_valid0, a_r_valid1}, 2'b00);

      // dual read
      a_r_en0 = 1; a_r_adr0 = 2; a_r_en1 = 1; a_r_adr1 = 3;
      tick();
      a_idle();
      chk("rd_data0", a_r_data0, 8'h8C);
      chk("rd_data1", a_r_data1, 8'hBE);
      chk("rd_valid", {a_r_valid0, a_r_valid1}, 2'b11);
      tick();
      chk("rd_valid_pulse", {a_r_valid0, a_r_valid1}, 2'b00);
      chk("rd_hold", {a_r_data0, a_r_data1}, 16'h8CBE);

      // same-address read/write
`ifdef REGFILE_WR_BYPASS_EN
      exp_same = 8'h55;
`else
      exp_same = 8'h86;
`endif
      a_w_en = 1; a_w_adr = 1; a_w_data = 8'h55;
      a_r_en0 = 1; a_r_adr0 = 1;
      tick();
      a_idle();
      chk("rw_same", a_r_data0, exp_same);
      a_r_en0 = 1; a_r_adr0 = 1;
      tick();
      a_idle();
      chk("rw_after", a_r_data0, 8'h55);

      // clear with a colliding write; read still sees old data
      a_clr = 1; a_w_en = 1; a_w_adr = 0; a_w_data = 8'hFF;
      a_r_en0 = 1; a_r_adr0 = 0;
      tick();
      chk("clr_busy1", a_busy, 1'b1);
      chk("clr_rd_pre", {a_r_valid0, a_r_data0}, {1'b1, 8'h8E});
      a_clr = 0; a_w_adr = 1; a_w_data = 8'h77;
      a_r_en0 = 1; a_r_adr0 = 1; a_r_en1 = 1; a_r_adr1 = 2;
      tick();
      chk("busy_rvalid", {a_busy, a_r_valid0, a_r_valid1}, 3'b100);
      tick();
      chk("busy3", a_busy, 1'b1);
      tick();
      chk("busy4", {a_busy, a_r_data0}, {1'b1, 8'h8E});
      a_clr = 1;
      tick();
      a_idle();
      chk("busy_fall", {a_busy, a_r_valid0, a_w_err}, 3'b000);
      for (int i = 0; i < 4; i++) begin
         a_r_en0 = 1; a_r_adr0 = 2'(i);
         a_r_en1 = 1; a_r_adr1 = 2'(3 - i);
         tick();
         a_idle();
         chk($sformatf("clr_rd%0d", i),
             {a_r_valid0, a_r_valid1, a_r_data0, a_r_data1},
             {2'b11, 16'h0000});
      end

      // reset in the middle of a sweep
      a_w_en = 1; a_w_adr = 2; a_w_data = 8'h3C; tick();
      a_idle();
      a_r_en0 = 1; a_r_adr0 = 2; tick();
      a_idle();
      chk("pre_rst_rd", a_r_data0, 8'h3C);
      a_clr = 1; tick();
      a_clr = 0; tick();
      chk("mid_busy", a_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", a_busy, 1'b0);
      chk("async_data", {a_r_data0, a_r_data1}, 16'h0000);
      chk("async_flags", {a_r_valid0, a_r_valid1, a_w_err}, 3'b000);
      tick();
      rst_n = 1'b1;
      a_r_en0 = 1; a_r_adr0 = 2; tick();
      a_idle();
      chk("rst_entry", {a_r_valid0, a_r_data0}, {1'b1, 8'h00});
      a_clr = 1; tick();
      a_clr = 0;
      cyc = 0;
      while (a_busy && cyc < 20) begin
         cyc++;
         tick();
      end
      chk("sweep_len", cyc, 4);

      // out of range on DEPTH=6
      b_w_en = 1; b_w_adr = 5; b_w_data = 8'h5A; tick();
      b_w_adr = 7; b_w_data = 8'hAA; tick();
      b_w_en = 0;
      chk("oor_werr", b_w_err, 1'b1);
      tick();
      chk("oor_werr_pulse", b_w_err, 1'b0);
      b_r_en0 = 1; b_r_adr0 = 6; b_r_en1 = 1; b_r_adr1 = 7;
      tick();
      b_r_en0 = 0; b_r_en1 = 0;
      chk("oor_rd6", {b_r_valid0, b_r_data0}, {1'b1, 8'h00});
      chk("oor_rd7", {b_r_valid1, b_r_data1}, {1'b1, 8'h00});
      for (int i = 0; i < 6; i++) begin
         b_r_en0 = 1; b_r_adr0 = 3'(i);
         tick();
         b_r_en0 = 0;
         chk($sformatf("oor_ent%0d", i), b_r_data0,
             (i == 5) ? 8'h5A : 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised register file with one write port and two independent registered read ports. It is the generalised successor of the 4x8 single-port register store. It adds:
- configurable width and depth
- an asynchronous active-low reset
- a multi-cycle hardware clear sweep with busy indication
- out-of-range write detection

It sits between the datapath control and the compute units and holds operands and weights for small ML kernels.

Parameters:
DATA_W, 8, width of each entry in bits
DEPTH, 4, number of entries (need not be a power of 2; minimum 2)
ADDR_W, $clog2(DEPTH), address width (localparam, derived from DEPTH; not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous assert, active-low
w_en  in  1  write strobe
w_adr  in  ADDR_W  write address
w_data  in  DATA_W  write data
r_en0  in  1  read strobe, port 0
r_adr0  in  ADDR_W  read address, port 0
r_data0  out  DATA_W  registered read data, port 0
r_valid0  out  1  one-cycle pulse, r_data0 updated this cycle
r_en1  in  1  read strobe, port 1
r_adr1  in  ADDR_W  read address, port 1
r_data1  out  DATA_W  registered read data, port 1
r_valid1  out  1  one-cycle pulse, r_data1 updated this cycle
clr  in  1  clear request (single-cycle pulse)
busy  out  1  high while the clear sweep runs
w_err  out  1  one-cycle pulse: write to address >= DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-sweep):
  - all entries = 0
  - r_data0 = r_data1 = 0; r_valid0 = r_valid1 = 0
  - busy = 0; w_err = 0
  - FSM = IDLE; sweep counter = 0
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr=1.
  - CLEAR zeroes entry cnt each cycle, cnt 0..DEPTH-1.
  - CLEAR -> IDLE after the cycle that writes entry DEPTH-1.
  - busy=1 for exactly DEPTH cycles, starting the cycle after clr is sampled.
- Write:
  - While !busy, w_en=1 with w_adr<DEPTH writes mem[w_adr]<=w_data at the clock edge.
  - w_adr>=DEPTH: no write; w_err=1 on the next cycle for one cycle.
- Read:
  - While !busy, r_enN=1 gives r_dataN<=mem[r_adrN] and r_validN=1 on the next edge (latency 1).
  - r_adrN>=DEPTH returns 0, with r_validN=1.
  - r_dataN holds its last value when r_validN=0.
  - Both ports may read the same or different addresses in the same cycle, with no conflict.
- During busy: w_en, r_en0/1 and clr are ignored; r_valid0/1=0; w_err=0.
- clr with w_en in the same IDLE cycle: clr wins and the write is dropped. Reads in that cycle are still serviced with pre-clear data.
- Read and write to the same address in the same cycle: the read returns the OLD contents (see Optional Feature).
- No combinational path from any input to any output.

Optional Feature:
Macro REGFILE_WR_BYPASS_EN.
- Defined: when r_enN and w_en are both active (not busy) and r_adrN==w_adr<DEPTH, r_dataN gets w_data (write-through bypass), independently on each port.
- Undefined: old contents are returned, as above.

Decomposition:
- Package regfile_pkg holds:
  - state enum rf_state_t {RF_IDLE, RF_CLEAR}
  - default constants RF_DATA_W=8, RF_DEPTH=4
- One natural sub-module, regfile_read_port, instantiated twice. It contains:
  - the address range check
  - the optional bypass mux
  - the r_data/r_valid registers
- Storage, write decode, FSM and sweep counter stay in regfile_2r1w.

Test Plan:
- Fill and read: DATA_W=8, DEPTH=4. Write 8'h8E, 8'h86, 8'h8C, 8'hBE to addresses 0..3. Then read port0 adr2 and port1 adr3 in the same cycle -> next cycle r_data0=8'h8C, r_data1=8'hBE, r_valid0=r_valid1=1 for exactly one cycle.
- Same-address read/write: mem[1]=8'h86; in one cycle w_en adr1 data 8'h55 with r_en0 adr1.
  - Without macro -> r_data0=8'h86.
  - With REGFILE_WR_BYPASS_EN -> r_data0=8'h55.
  - Either build: a following read returns 8'h55.
- Clear sweep: after the fill, pulse clr together with w_en adr0 data 8'hFF.
  - busy=1 for exactly 4 cycles.
  - w_en/r_en issued during busy leave the entries unchanged and give r_valid=0.
  - After busy falls, reads of all addresses return 8'h00.
- Reset mid-sweep: pull rst_n low 2 cycles into CLEAR -> busy=0 immediately (asynchronously), all outputs 0. After release, clr starts a fresh 4-cycle sweep.
- Out of range: DEPTH=6, ADDR_W=3.
  - Write adr 7 data 8'hAA -> w_err=1 for one cycle; no entry changes.
  - Read adr 6 -> r_data0=8'h00, r_valid0=1.
